croc_collision: RTL and testbench

- Consumes the crocodile's vertical position and the frog's position once per video frame.
- Decides whether the frog has been caught, using debounced rectangle overlap.
- Owns the frog's lives count, the post-hit invulnerability/blink window and the game-over flag.
- Outputs feed the frog movement block (respawn) and the VGA renderer (blink, game over).

---
 rtl/croc_collision.sv | 146 ++++++++++++++
 tb/tb_croc_collision.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/croc_collision.sv
// Crocodile/frog collision judge: debounced rectangle overlap, lives,
// post-hit invulnerability blink window and game-over handling.
module croc_collision #(
    parameter int CROC_X       = 300,
    parameter int CROC_W       = 64,
    parameter int CROC_H       = 32,
    parameter int FROG_W       = 16,
    parameter int FROG_H       = 16,
    parameter int LIVES        = 3,
    parameter int FLASH_FRAMES = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic [9:0] croc_y,
    input  logic [9:0] frog_x,
    input  logic [9:0] frog_y,
    input  logic       restart,
    output logic       hit,
    output logic       frog_reset,
    output logic [1:0] lives,
    output logic       flash,
    output logic       game_over
);

    typedef enum logic [1:0] {
        PLAY   = 2'd0,
        INVULN = 2'd1,
        OVER   = 2'd2
    } state_t;

    localparam logic [10:0] CROC_LEFT  = 11'(CROC_X);
    localparam logic [10:0] CROC_RIGHT = 11'(CROC_X + CROC_W);
    localparam logic [10:0] CROC_HGT   = 11'(CROC_H);
    localparam logic [10:0] FROG_WID   = 11'(FROG_W);
    localparam logic [10:0] FROG_HGT   = 11'(FROG_H);
    localparam logic [1:0]  LIVES_INIT = 2'(LIVES);
    localparam logic [7:0]  FLASH_INIT = 8'(FLASH_FRAMES);

    state_t     state;
    state_t     state_next;
    logic [1:0] lives_next;
    logic       streak;
    logic       streak_next;
    logic [7:0] timer;
    logic [7:0] timer_next;
    logic       hit_next;
    logic       overlap;

    logic [10:0] frog_x_ext;
    logic [10:0] frog_y_ext;
    logic [10:0] croc_y_ext;

    // Strict rectangle overlap at 11 bits so edge sums never wrap;
    // touching edges are deliberately not a collision.
    always_comb begin
        frog_x_ext = {1'b0, frog_x};
        frog_y_ext = {1'b0, frog_y};
        croc_y_ext = {1'b0, croc_y};
        overlap = (frog_x_ext < CROC_RIGHT)
               && ((frog_x_ext + FROG_WID) > CROC_LEFT)
               && (frog_y_ext < (croc_y_ext + CROC_HGT))
               && ((frog_y_ext + FROG_HGT) > croc_y_ext);
    end

    // Next-state logic: debounce, life accounting, blink timer, restart.
    always_comb begin
        state_next  = state;
        lives_next  = lives;
        streak_next = streak;
        timer_next  = timer;
        hit_next    = 1'b0;
        case (state)
            PLAY: begin
                if (frame_tick) begin
                    if (overlap && streak) begin
                        hit_next    = 1'b1;
                        streak_next = 1'b0;
                        lives_next  = (lives != 2'd0) ? lives - 2'd1 : 2'd0;
                        if (lives <= 2'd1) begin
                            state_next = OVER;
                            timer_next = 8'd0;
                        end else begin
                            state_next = INVULN;
                            timer_next = FLASH_INIT;
                        end
                    end else begin
                        streak_next = overlap;
                    end
                end
            end
            INVULN: begin
                streak_next = 1'b0;
                if (frame_tick) begin
                    if (timer <= 8'd1) begin
                        timer_next = 8'd0;
                        state_next = PLAY;
                    end else begin
                        timer_next = timer - 8'd1;
                    end
                end
            end
            OVER: begin
                streak_next = 1'b0;
                timer_next  = 8'd0;
                lives_next  = 2'd0;
                if (restart) begin
                    state_next = PLAY;
                    lives_next = LIVES_INIT;
                end
            end
            default: begin
                state_next  = PLAY;
                lives_next  = LIVES_INIT;
                streak_next = 1'b0;
                timer_next  = 8'd0;
            end
        endcase
    end

    // State register; hit and frog_reset are registered copies of the trigger.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= PLAY;
            lives      <= LIVES_INIT;
            streak     <= 1'b0;
            timer      <= 8'd0;
            hit        <= 1'b0;
            frog_reset <= 1'b0;
        end else begin
            state      <= state_next;
            lives      <= lives_next;
            streak     <= streak_next;
            timer      <= timer_next;
            hit        <= hit_next;
            frog_reset <= hit_next;
        end
    end

    // Renderer-facing status decoded from the current state.
    always_comb begin
        flash     = (state == INVULN) && timer[3];
        game_over = (state == OVER);
    end

endmodule

// File: tb/tb_croc_collision.sv
// Directed, table-driven bench for croc_collision.
module tb_croc_collision;

    logic       clk;
    logic       rst;
    logic       frame_tick;
    logic [9:0] croc_y;
    logic [9:0] frog_x;
    logic [9:0] frog_y;
    logic       restart;
    logic       hit;
    logic       frog_reset;
    logic [1:0] lives;
    logic       flash;
    logic       game_over;

    int n_compared   = 0;
    int n_mismatched = 0;

    croc_collision dut (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .croc_y     (croc_y),
        .frog_x     (frog_x),
        .frog_y     (frog_y),
        .restart    (restart),
        .hit        (hit),
        .frog_reset (frog_reset),
        .lives      (lives),
        .flash      (flash),
        .game_over  (game_over)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [9:0] fx;
        logic [9:0] fy;
        logic [9:0] cy;
        int         reps;
        logic       exp_hit;
        logic       exp_fr;
        logic [1:0] exp_lives;
        logic       exp_flash;
        logic       exp_over;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs[NVEC];

    task automatic check(input string name, input int act, input int exp);
        n_compared++;
        if (act != exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_output(input string tag, input logic e_hit, input logic e_fr,
                                input logic [1:0] e_lives, input logic e_flash,
                                input logic e_over);
        check($sformatf("%s.hit", tag), int'(hit), int'(e_hit));
        check($sformatf("%s.frog_reset", tag), int'(frog_reset), int'(e_fr));
        check($sformatf("%s.lives", tag), int'(lives), int'(e_lives));
        check($sformatf("%s.flash", tag), int'(flash), int'(e_flash));
        check($sformatf("%s.game_over", tag), int'(game_over), int'(e_over));
    endtask

    task automatic apply_tick(input logic [9:0] fx, input logic [9:0] fy,
                              input logic [9:0] cy, input logic rs);
        @(negedge clk);
        frog_x     = fx;
        frog_y     = fy;
        croc_y     = cy;
        frame_tick = 1'b1;
        restart    = rs;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        restart    = 1'b0;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // fx, fy, cy, reps, hit, frog_reset, lives, flash, game_over
        vecs[0]  = '{10'd0,   10'd0,   10'd200, 10, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0};
        vecs[1]  = '{10'd310, 10'd205, 10'd200, 1,  1'b0, 1'b0, 2'd3, 1'b0, 1'b0};
        vecs[2]  = '{10'd0,   10'd0,   10'd200, 1,  1'b0, 1'b0, 2'd3, 1'b0, 1'b0};
        vecs[3]  = '{10'd310, 10'd205, 10'd200, 1,  1'b0, 1'b0, 2'd3, 1'b0, 1'b0};
        vecs[4]  = '{10'd310, 10'd205, 10'd200, 1,  1'b1, 1'b1, 2'd2, 1'b1, 1'b0};
        vecs[5]  = '{10'd310, 10'd205, 10'd200, 59, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0};
        vecs[6]  = '{10'd310, 10'd205, 10'd200, 1,  1'b0, 1'b0, 2'd2, 1'b0, 1'b0};
        vecs[7]  = '{10'd310, 10'd205, 10'd200, 1,  1'b0, 1'b0, 2'd2, 1'b0, 1'b0};
        vecs[8]  = '{10'd0,   10'd0,   10'd200, 1,  1'b0, 1'b0, 2'd2, 1'b0, 1'b0};
        vecs[9]  = '{10'd364, 10'd205, 10'd200, 2,  1'b0, 1'b0, 2'd2, 1'b0, 1'b0};
        vecs[10] = '{10'd284, 10'd205, 10'd200, 2,  1'b0, 1'b0, 2'd2, 1'b0, 1'b0};
        vecs[11] = '{10'd363, 10'd205, 10'd200, 2,  1'b1, 1'b1, 2'd1, 1'b1, 1'b0};
        vecs[12] = '{10'd0,   10'd0,   10'd200, 60, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0};
        vecs[13] = '{10'd310, 10'd232, 10'd200, 2,  1'b0, 1'b0, 2'd1, 1'b0, 1'b0};
        vecs[14] = '{10'd310, 10'd184, 10'd200, 2,  1'b0, 1'b0, 2'd1, 1'b0, 1'b0};
        vecs[15] = '{10'd310, 10'd231, 10'd200, 2,  1'b1, 1'b1, 2'd0, 1'b0, 1'b1};
        vecs[16] = '{10'd310, 10'd205, 10'd200, 3,  1'b0, 1'b0, 2'd0, 1'b0, 1'b1};

        rst        = 1'b1;
        frame_tick = 1'b0;
        restart    = 1'b0;
        croc_y     = 10'd200;
        frog_x     = 10'd0;
        frog_y     = 10'd0;

        // Two reset cycles, then the reset state.
        idle_cycle();
        idle_cycle();
        check_output("reset", 1'b0, 1'b0, 2'd3, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Table: each row is applied reps times, checked after the last tick.
        for (int i = 0; i < NVEC; i++) begin
            for (int r = 0; r < vecs[i].reps; r++)
                apply_tick(vecs[i].fx, vecs[i].fy, vecs[i].cy, 1'b0);
            check_output($sformatf("vec%0d", i), vecs[i].exp_hit, vecs[i].exp_fr,
                         vecs[i].exp_lives, vecs[i].exp_flash, vecs[i].exp_over);
        end

        // Restart coincident with an overlapping frame: that frame is not evaluated.
        apply_tick(10'd310, 10'd205, 10'd200, 1'b1);
        check_output("restart", 1'b0, 1'b0, 2'd3, 1'b0, 1'b0);
        apply_tick(10'd310, 10'd205, 10'd200, 1'b0);
        check_output("restart_first", 1'b0, 1'b0, 2'd3, 1'b0, 1'b0);
        apply_tick(10'd310, 10'd205, 10'd200, 1'b0);
        check_output("restart_hit", 1'b1, 1'b1, 2'd2, 1'b1, 1'b0);

        // Blink pattern: after k ticks the timer holds 60-k, blink is its bit 3.
        for (int k = 1; k <= 30; k++) begin
            int t;
            t = 60 - k;
            apply_tick(10'd0, 10'd0, 10'd200, 1'b0);
            check($sformatf("blink%0d", k), int'(flash), (t >> 3) & 1);
        end

        // Reset in the middle of the invulnerable window.
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_output("mid_reset", 1'b0, 1'b0, 2'd3, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Debounce state survives idle cycles; hit lands exactly one cycle later.
        apply_tick(10'd310, 10'd205, 10'd200, 1'b0);
        check_output("fresh_first", 1'b0, 1'b0, 2'd3, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            idle_cycle();
            check($sformatf("gap%0d.hit", c), int'(hit), 0);
        end
        apply_tick(10'd310, 10'd205, 10'd200, 1'b0);
        check_output("fresh_hit", 1'b1, 1'b1, 2'd2, 1'b1, 1'b0);
        idle_cycle();
        check_output("hit_pulse_end", 1'b0, 1'b0, 2'd2, 1'b1, 1'b0);

        // Restart outside the game-over state does nothing.
        @(negedge clk);
        restart = 1'b1;
        @(posedge clk);
        #1;
        restart = 1'b0;
        check_output("restart_ignored", 1'b0, 1'b0, 2'd2, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
